// File: rtl/mips_pipe_core.sv
// Five-stage pipelined RISC core: unified word-addressed memory and 32x32 register file,
// EX/MEM and MEM/WB forwarding, branches resolved in EX, HLT drains the pipe and halts.
module mips_pipe_core #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned PC_W      = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b000100;
  localparam logic [OP_W-1:0] OP_MUL   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
  localparam logic [OP_W-1:0] OP_SW    = 6'b001001;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'b001011;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_BNEQZ = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQZ  = 6'b001110;
  localparam logic [OP_W-1:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] ir;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] dest;
    logic            wen;
    logic            is_load;
    logic            is_store;
    logic            is_bnz;
    logic            is_bz;
    logic            is_hlt;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wen;
    logic            is_load;
    logic            is_store;
    logic            is_hlt;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wen;
    logic            is_hlt;
    logic [XLEN-1:0] val;
  } mem_wb_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  logic [XLEN-1:0] Mem [MEM_WORDS];
  logic [XLEN-1:0] Reg [32];

  logic [PC_W-1:0] pc;
  if_id_t  if_id;
  id_ex_t  id_ex,  id_d;
  ex_mem_t ex_mem, ex_d;
  mem_wb_t mem_wb, wb_d;
  state_t  st_q, st_d;

  logic            wb_we;
  logic            id_is_hlt;
  logic            hlt_issue_c;
  logic            fetch_en_c;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic [XLEN-1:0] ex_a, ex_b, ex_alu;
  logic [PC_W-1:0] mem_addr;

  assign wb_we     = mem_wb.valid && mem_wb.wen && (mem_wb.dest != '0);
  assign id_is_hlt = if_id.valid && (if_id.ir[31:26] == OP_HLT);
  assign mem_addr  = ex_mem.alu[PC_W-1:0];

  // ID: decode plus write-through register read
  always_comb begin
    id_d         = '0;
    id_d.valid   = if_id.valid;
    id_d.op      = if_id.ir[31:26];
    id_d.rs      = if_id.ir[25:21];
    id_d.rt      = if_id.ir[20:16];
    id_d.imm     = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
    id_d.pc      = if_id.pc;
    if (id_d.rs == '0)                     id_d.a = '0;
    else if (wb_we && mem_wb.dest == id_d.rs) id_d.a = mem_wb.val;
    else                                   id_d.a = Reg[id_d.rs];
    if (id_d.rt == '0)                     id_d.b = '0;
    else if (wb_we && mem_wb.dest == id_d.rt) id_d.b = mem_wb.val;
    else                                   id_d.b = Reg[id_d.rt];
    case (id_d.op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_d.dest = if_id.ir[15:11];
        id_d.wen  = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        id_d.dest = id_d.rt;
        id_d.wen  = 1'b1;
      end
      OP_LW: begin
        id_d.dest    = id_d.rt;
        id_d.wen     = 1'b1;
        id_d.is_load = 1'b1;
      end
      OP_SW:    id_d.is_store = 1'b1;
      OP_BNEQZ: id_d.is_bnz   = 1'b1;
      OP_BEQZ:  id_d.is_bz    = 1'b1;
      OP_HLT:   id_d.is_hlt   = 1'b1;
      default:  ;
    endcase
    if (!if_id.valid) id_d = '0;
  end

  // EX: operand forwarding (loads are not forwarded from EX/MEM), ALU and branch resolution
  always_comb begin
    ex_a = id_ex.a;
    if (ex_mem.valid && ex_mem.wen && !ex_mem.is_load && ex_mem.dest != '0 && ex_mem.dest == id_ex.rs)
      ex_a = ex_mem.alu;
    else if (wb_we && mem_wb.dest == id_ex.rs)
      ex_a = mem_wb.val;
    ex_b = id_ex.b;
    if (ex_mem.valid && ex_mem.wen && !ex_mem.is_load && ex_mem.dest != '0 && ex_mem.dest == id_ex.rt)
      ex_b = ex_mem.alu;
    else if (wb_we && mem_wb.dest == id_ex.rt)
      ex_b = mem_wb.val;

    case (id_ex.op)
      OP_ADD:       ex_alu = ex_a + ex_b;
      OP_SUB:       ex_alu = ex_a - ex_b;
      OP_AND:       ex_alu = ex_a & ex_b;
      OP_OR:        ex_alu = ex_a | ex_b;
      OP_SLT:       ex_alu = XLEN'($signed(ex_a) < $signed(ex_b));
      OP_MUL:       ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + id_ex.imm;
      OP_SUBI:      ex_alu = ex_a - id_ex.imm;
      OP_SLTI:      ex_alu = XLEN'($signed(ex_a) < $signed(id_ex.imm));
      default:      ex_alu = '0;
    endcase

    ex_taken  = id_ex.valid && ((id_ex.is_bnz && ex_a != '0) || (id_ex.is_bz && ex_a == '0));
    ex_target = id_ex.pc + PC_W'(1) + id_ex.imm[PC_W-1:0];

    ex_d          = '0;
    ex_d.valid    = id_ex.valid;
    ex_d.dest     = id_ex.dest;
    ex_d.wen      = id_ex.wen;
    ex_d.is_load  = id_ex.is_load;
    ex_d.is_store = id_ex.is_store;
    ex_d.is_hlt   = id_ex.is_hlt;
    ex_d.alu      = ex_alu;
    ex_d.sdata    = ex_b;
  end

  // MEM: load data selection
  always_comb begin
    wb_d        = '0;
    wb_d.valid  = ex_mem.valid;
    wb_d.dest   = ex_mem.dest;
    wb_d.wen    = ex_mem.wen;
    wb_d.is_hlt = ex_mem.is_hlt;
    wb_d.val    = ex_mem.is_load ? Mem[mem_addr] : ex_mem.alu;
  end

  // Run-control FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_RUN;
      halted <= 1'b0;
    end else begin
      st_q   <= st_d;
      halted <= (st_d == S_HALT);
    end
  end

  // Run-control FSM: next state; a taken branch in EX squashes an HLT sitting in ID
  always_comb begin
    st_d        = st_q;
    hlt_issue_c = id_is_hlt && !ex_taken;
    case (st_q)
      S_RUN:   if (hlt_issue_c) st_d = S_DRAIN;
      S_DRAIN: if (mem_wb.valid && mem_wb.is_hlt) st_d = S_HALT;
      S_HALT:  st_d = S_HALT;
      default: st_d = S_RUN;
    endcase
  end

  // Run-control FSM: outputs
  always_comb begin
    fetch_en_c = 1'b0;
    if (st_q == S_RUN && !hlt_issue_c) fetch_en_c = 1'b1;
  end

  // Pipeline registers; reset turns every stage into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (ex_taken)        pc <= ex_target;
      else if (fetch_en_c) pc <= pc + PC_W'(1);
      if (ex_taken || !fetch_en_c) if_id <= '0;
      else                         if_id <= '{valid: 1'b1, pc: pc, ir: Mem[pc]};
      id_ex  <= ex_taken ? id_ex_t'('0) : id_d;
      ex_mem <= ex_d;
      mem_wb <= wb_d;
    end
  end

  // Architectural state is not reset so it can be preloaded under reset
  always_ff @(posedge clk) begin
    if (ex_mem.valid && ex_mem.is_store) Mem[mem_addr] <= ex_mem.sdata;
    if (wb_we) Reg[mem_wb.dest] <= mem_wb.val;
  end

endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed bench for mips_pipe_core: preloads programs hierarchically, runs to halt,
// and compares a table of expected register/memory values plus reset corner cases.
module tb_mips_pipe_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int tests = 0;
  int failed = 0;

  mips_pipe_core dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  typedef struct {
    int          prog;
    bit          is_mem;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  localparam int NPROG = 6;
  logic [31:0] prog [NPROG][8];
  chk_t chk [$];

  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int p, input bit m, input int idx, input logic [31:0] e, input string n);
    chk_t c;
    c.prog = p; c.is_mem = m; c.idx = idx; c.exp = e; c.name = n;
    chk.push_back(c);
  endtask

  // Hold reset, preload memory and registers, then release
  task automatic load_prog(input int p);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) dut.Mem[i] = prog[p][i];
    dut.Mem[120] = 32'd95;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name, output int cycles);
    cycles = 0;
    while (!halted && cycles < 80) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_halt"}, 32'(halted), 32'd1);
  endtask

  int cyc;

  initial begin
    // Opcodes: ADD 00 SUB 01 AND 02 OR 03 SLT 04 MUL 05 LW 08 SW 09 ADDI 0A SUBI 0B SLTI 0C BNEQZ 0D BEQZ 0E
    for (int p = 0; p < NPROG; p++)
      for (int i = 0; i < 8; i++) prog[p][i] = 32'hFC00_0000;
    // 0: load/store with forwarding through MEM/WB
    prog[0][0] = enc_i(6'h0A, 0, 1, 120);
    prog[0][1] = enc_r(6'h03, 3, 3, 3);
    prog[0][2] = enc_i(6'h08, 1, 2, 0);
    prog[0][3] = enc_r(6'h03, 3, 3, 3);
    prog[0][4] = enc_i(6'h0A, 2, 2, 45);
    prog[0][5] = enc_r(6'h03, 3, 3, 3);
    prog[0][6] = enc_i(6'h09, 1, 2, 1);
    // 1: back-to-back ALU forwarding
    prog[1][0] = enc_i(6'h0A, 0, 1, 10);
    prog[1][1] = enc_i(6'h0A, 1, 2, 20);
    prog[1][2] = enc_r(6'h00, 1, 2, 3);
    prog[1][3] = enc_r(6'h05, 3, 3, 4);
    // 2: signed ops
    prog[2][0] = enc_i(6'h0A, 0, 1, -5);
    prog[2][1] = enc_i(6'h0C, 1, 2, 0);
    prog[2][2] = enc_r(6'h04, 0, 1, 3);
    prog[2][3] = enc_r(6'h01, 0, 1, 4);
    prog[2][4] = enc_r(6'h04, 1, 0, 5);
    // 3: counted loop; word 5 must execute exactly once
    prog[3][0] = enc_i(6'h0A, 0, 1, 3);
    prog[3][1] = enc_i(6'h0A, 0, 2, 0);
    prog[3][2] = enc_i(6'h0A, 2, 2, 7);
    prog[3][3] = enc_i(6'h0B, 1, 1, 1);
    prog[3][4] = enc_i(6'h0D, 1, 0, -3);
    prog[3][5] = enc_i(6'h0A, 6, 6, 1);
    // 4: R0 protection
    prog[4][0] = enc_i(6'h0A, 0, 0, 55);
    prog[4][1] = enc_r(6'h00, 0, 0, 5);
    // 5: BEQZ taken skip, BNEQZ not taken, undefined opcode as NOP
    prog[5][0] = enc_i(6'h0E, 0, 0, 1);
    prog[5][1] = enc_i(6'h0A, 0, 7, 1);
    prog[5][2] = enc_i(6'h0A, 0, 8, 2);
    prog[5][3] = enc_i(6'h0D, 0, 0, 3);
    prog[5][4] = enc_r(6'h10, 1, 1, 9);
    prog[5][5] = enc_i(6'h0A, 8, 10, 5);

    add(0, 0, 1, 32'd120, "ldst_r1");
    add(0, 0, 2, 32'd140, "ldst_r2");
    add(0, 1, 121, 32'd140, "ldst_mem121");
    add(0, 1, 120, 32'd95, "ldst_mem120");
    add(1, 0, 2, 32'd30, "fwd_r2");
    add(1, 0, 3, 32'd40, "fwd_r3");
    add(1, 0, 4, 32'd1600, "fwd_r4");
    add(2, 0, 1, 32'hFFFF_FFFB, "sgn_r1");
    add(2, 0, 2, 32'd1, "sgn_slti");
    add(2, 0, 3, 32'd0, "sgn_slt0");
    add(2, 0, 4, 32'd5, "sgn_sub");
    add(2, 0, 5, 32'd1, "sgn_slt1");
    add(3, 0, 1, 32'd0, "loop_r1");
    add(3, 0, 2, 32'd21, "loop_r2");
    add(3, 0, 6, 32'd7, "loop_shadow_r6");
    add(4, 0, 0, 32'd0, "r0_r0");
    add(4, 0, 5, 32'd0, "r0_r5");
    add(5, 0, 7, 32'd7, "br_squash_r7");
    add(5, 0, 8, 32'd2, "br_r8");
    add(5, 0, 9, 32'd9, "undef_r9");
    add(5, 0, 10, 32'd7, "br_r10");

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(dut.pc), 32'd0);

    for (int p = 0; p < NPROG; p++) begin
      load_prog(p);
      wait_halt($sformatf("prog%0d", p), cyc);
      if (p == 0) begin
        check("ldst_latency_le30", 32'(cyc <= 30), 32'd1);
        repeat (5) @(negedge clk);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_writes", dut.Mem[122], 32'd0);
      end
      foreach (chk[j])
        if (chk[j].prog == p)
          check(chk[j].name, chk[j].is_mem ? dut.Mem[chk[j].idx] : dut.Reg[chk[j].idx], chk[j].exp);
    end

    // Reset mid-loop aborts immediately, then the program reruns cleanly
    load_prog(3);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", 32'(dut.pc), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_wb_bubble", 32'(dut.mem_wb.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt("midrst", cyc);
    check("midrst_r1", dut.Reg[1], 32'd0);
    check("midrst_r2", dut.Reg[2], 32'd21);

    // Reset after halt clears halted asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("postrst_halted", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
